core_bus_target: RTL and testbench
==================================

Name: core_bus_target

Overview:
- Bus responder for the CPU core's external bus: the target end of the address/data/rdwr/ready/phy2 interface.
- Decodes an address window and serves it from internal single-port RAM, mirrored across the window.
- Inserts programmable wait states by holding O_ready low; the core repeats the bus cycle while O_ready is low.
- Sits beside the core at top level; read data is muxed onto the core's read-data input when O_rd_valid is high.

Parameters:
- ADDR_BASE, 16'h0000, window base; select when (I_addr & ADDR_MASK) == ADDR_BASE.
- ADDR_MASK, 16'hE000, window decode mask.
- RAM_AW, 11, RAM address width (2 KiB); RAM index = I_addr[RAM_AW-1:0], mirrored.
- WAIT_STATES, 0, stalled bus cycles per selected access (0..15).

Ports:
- I_clock  in  1  system clock, same clock as the core.
- I_reset  in  1  reset, asynchronous, active-low.
- I_phy2  in  1  core phase-2 output; high for 6 of 12 clocks per bus cycle.
- I_addr  in  16  core address.
- I_wr_data  in  8  core write data.
- I_rdwr  in  1  1 = read, 0 = write.
- O_rd_data  out  8  read data; valid while O_rd_valid is high.
- O_rd_valid  out  1  target is driving a read this cycle.
- O_ready  out  1  0 = stall the core's current bus cycle.

Behaviour:
- Reset (I_reset low, async): state IDLE, O_ready = 1, O_rd_valid = 0, O_rd_data = 8'h00, wait counter = 0. RAM contents are not cleared.
- Edge detect:
  - Register I_phy2 each clock.
  - rise = phy2 & ~last.
  - fall = ~phy2 & last.
- O_ready changes only on the clock of rise, so it is stable through phy2-high and the fall clock, where the core samples it.
- sel = ((I_addr & ADDR_MASK) == ADDR_BASE), evaluated at rise. Address, rdwr and wr_data are captured at rise.
- States: IDLE, WAIT, ACCESS.
- IDLE:
  - rise & sel & WAIT_STATES > 0 → O_ready <= 0, cnt <= WAIT_STATES, state WAIT.
  - rise & sel & WAIT_STATES == 0 → state ACCESS; the access launches this cycle.
  - rise & ~sel → remain IDLE, O_ready stays 1.
- WAIT:
  - fall → cnt <= cnt - 1.
  - rise & cnt == 0 → O_ready <= 1, state ACCESS, access launches.
  - rise & cnt != 0 → stay in WAIT, O_ready stays 0.
  - Result: exactly WAIT_STATES stalled bus cycles.
- ACCESS, read:
  - RAM read issued on the rise clock.
  - O_rd_data registered one clock later; O_rd_valid = 1 from rise+1 through the fall clock inclusive, then 0.
  - Read latency: 1 clock from rise. It must land before fall; guaranteed because phy2-high lasts 6 clocks.
- ACCESS, write: RAM written with the captured wr_data on the fall clock. O_rd_valid stays 0.
- ACCESS exit: on fall, state <= IDLE.
- Writes commit only in ACCESS, never during stalled cycles. Reads during stalled cycles do not assert O_rd_valid.
- Mid-access change: if I_addr/I_rdwr change while in WAIT (protocol violation), the values captured at the first rise are used. No re-decode until back in IDLE.
- RAM index wraps modulo 2^RAM_AW: mirrors alias the same byte.
- Reset mid-access: state aborts to IDLE, any pending write is dropped, O_ready = 1 immediately (async).
- Phy2 stuck or missing: state holds, no timeout.
- Unselected bus cycles: O_rd_valid = 0, O_ready = 1, no RAM activity.

Decomposition:
- Package core_bus_signals:
  - state typedef (IDLE/WAIT/ACCESS, 2 bits).
  - phy2 edge-kind constants.
  - RW_READ = 1'b1, RW_WRITE = 1'b0.
- Sub-module core_bus_ram: parameterised synchronous single-port RAM.
  - Ports: clock, address, write enable, write data, registered read data.
  - Parameters: RAM_AW, width 8.
  - Inferable as block RAM.

Test Plan:
- WAIT_STATES=0: write 8'hA5 to 16'h0123, then read 16'h0123 → O_rd_valid high from rise+1 through fall, O_rd_data = 8'hA5, O_ready constantly 1.
- Mirroring: write 8'h3C to 16'h0800, read 16'h1800 and 16'h0000 → both return 8'h3C.
- Outside window: read 16'h4000 → O_rd_valid = 0, O_ready = 1; a write of 8'hFF to 16'h4000 leaves 16'h0000 unchanged.
- WAIT_STATES=3: read 16'h0010 → O_ready low across exactly 3 phy2 falls, then the data is returned on the 4th bus cycle; the core completes the access with I_ready high.
- WAIT_STATES=2, write 8'h77 to 16'h0020: assert reset during the second stalled cycle → O_ready = 1 immediately, then a read of 16'h0020 returns the pre-write value.
- Back-to-back: read 16'h0001, then write 16'h0002, then read 16'h0002 on consecutive bus cycles with WAIT_STATES=0 → no lost cycles, and the final read returns the written byte.

Source files
------------

// File: rtl/core_bus_signals.sv
// Shared types and helpers for the core bus target: FSM states, phy2 edge kinds,
// read/write encoding and address-window decode.
package core_bus_signals;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } bus_state_e;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } phy2_edge_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  function automatic phy2_edge_e phy2_edge(input logic now_v, input logic last_v);
    phy2_edge_e kind_v;
    case ({now_v, last_v})
      2'b10:   kind_v = EDGE_RISE;
      2'b01:   kind_v = EDGE_FALL;
      default: kind_v = EDGE_NONE;
    endcase
    return kind_v;
  endfunction

  function automatic logic in_window(input logic [15:0] addr_v, input logic [15:0] base_v,
                                     input logic [15:0] mask_v);
    return ((addr_v & mask_v) == base_v);
  endfunction

endpackage

// File: rtl/core_bus_ram.sv
// Synchronous single-port RAM with registered read data (read-first), block-RAM inferable.
module core_bus_ram #(
  parameter int RAM_AW = 11,
  parameter int DW     = 8
) (
  input  logic              clock,
  input  logic [RAM_AW-1:0] addr,
  input  logic              we,
  input  logic [DW-1:0]     wr_data,
  output logic [DW-1:0]     rd_data
);

  logic [DW-1:0] mem_r [0:(1 << RAM_AW) - 1];

  // Single port: optional write plus registered read of the same address.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[addr] <= wr_data;
    end
    rd_data <= mem_r[addr];
  end

endmodule

// File: rtl/core_bus_target.sv
// Bus target for the core's address/data/rdwr/ready/phy2 bus: decodes a mirrored RAM
// window and stretches selected bus cycles with programmable wait states.
module core_bus_target
  import core_bus_signals::*;
#(
  parameter logic [15:0] ADDR_BASE   = 16'h0000,
  parameter logic [15:0] ADDR_MASK   = 16'hE000,
  parameter int          RAM_AW      = 11,
  parameter logic [3:0]  WAIT_STATES = 4'd0
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_phy2,
  input  logic [15:0] I_addr,
  input  logic [7:0]  I_wr_data,
  input  logic        I_rdwr,
  output logic [7:0]  O_rd_data,
  output logic        O_rd_valid,
  output logic        O_ready
);

  logic              phy2_last_r;
  phy2_edge_e        edge_s;
  logic              rise_s;
  logic              fall_s;
  logic              sel_s;
  bus_state_e        state_r;
  logic [3:0]        cnt_r;
  logic [RAM_AW-1:0] addr_r;
  logic              rdwr_r;
  logic [7:0]        wr_data_r;
  logic              ready_r;
  logic              rd_valid_r;
  logic [RAM_AW-1:0] ram_addr_s;
  logic              ram_we_s;
  logic [7:0]        ram_q_s;

  // Phase-2 edge classification and window decode.
  always_comb begin
    edge_s = phy2_edge(I_phy2, phy2_last_r);
    rise_s = (edge_s == EDGE_RISE);
    fall_s = (edge_s == EDGE_FALL);
    sel_s  = in_window(I_addr, ADDR_BASE, ADDR_MASK);
  end

  // In IDLE the live address feeds the RAM so a zero-wait read launches on the rise clock.
  always_comb begin
    if (state_r == ST_IDLE) begin
      ram_addr_s = I_addr[RAM_AW-1:0];
    end else begin
      ram_addr_s = addr_r;
    end
    if ((state_r == ST_ACCESS) && fall_s && (rdwr_r == RW_WRITE)) begin
      ram_we_s = 1'b1;
    end else begin
      ram_we_s = 1'b0;
    end
  end

  // Previous phy2 sample for edge detection.
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      phy2_last_r <= 1'b0;
    end else begin
      phy2_last_r <= I_phy2;
    end
  end

  // Bus FSM; O_ready only moves on a rise so it is steady when the core samples it.
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      addr_r     <= '0;
      rdwr_r     <= RW_READ;
      wr_data_r  <= 8'h00;
      ready_r    <= 1'b1;
      rd_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rise_s && sel_s) begin
            addr_r    <= I_addr[RAM_AW-1:0];
            rdwr_r    <= I_rdwr;
            wr_data_r <= I_wr_data;
            if (WAIT_STATES != 4'd0) begin
              ready_r <= 1'b0;
              cnt_r   <= WAIT_STATES;
              state_r <= ST_WAIT;
            end else begin
              state_r    <= ST_ACCESS;
              rd_valid_r <= (I_rdwr == RW_READ);
            end
          end
        end
        ST_WAIT: begin
          if (rise_s && (cnt_r == 4'd0)) begin
            ready_r    <= 1'b1;
            state_r    <= ST_ACCESS;
            rd_valid_r <= (rdwr_r == RW_READ);
          end else if (fall_s && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_ACCESS: begin
          if (fall_s) begin
            state_r    <= ST_IDLE;
            rd_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          ready_r    <= 1'b1;
          rd_valid_r <= 1'b0;
        end
      endcase
    end
  end

  core_bus_ram #(
    .RAM_AW(RAM_AW),
    .DW    (8)
  ) u_ram (
    .clock  (I_clock),
    .addr   (ram_addr_s),
    .we     (ram_we_s),
    .wr_data(wr_data_r),
    .rd_data(ram_q_s)
  );

  assign O_ready    = ready_r;
  assign O_rd_valid = rd_valid_r;
  assign O_rd_data  = rd_valid_r ? ram_q_s : 8'h00;

endmodule

// File: tb/tb_core_bus_target.sv
// Self-checking bench: three targets (0, 3 and 2 wait states) driven by a core-like bus model,
// with a read-data scoreboard fed from a byte model of each RAM.
module tb_core_bus_target;
  import core_bus_signals::*;

  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  logic [2:0]  phy2;
  logic [15:0] addr;
  logic [7:0]  wd;
  logic        rdwr;
  logic [7:0]  rd_data_w [3];
  logic [2:0]  rd_valid_w;
  logic [2:0]  ready_w;

  int errors = 0;
  int checks = 0;
  logic [7:0] model_mem [3][2048];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  core_bus_target #(.WAIT_STATES(4'd0)) u_ws0 (
    .I_clock(clk), .I_reset(rst_n[0]), .I_phy2(phy2[0]), .I_addr(addr), .I_wr_data(wd),
    .I_rdwr(rdwr), .O_rd_data(rd_data_w[0]), .O_rd_valid(rd_valid_w[0]), .O_ready(ready_w[0]));
  core_bus_target #(.WAIT_STATES(4'd3)) u_ws3 (
    .I_clock(clk), .I_reset(rst_n[1]), .I_phy2(phy2[1]), .I_addr(addr), .I_wr_data(wd),
    .I_rdwr(rdwr), .O_rd_data(rd_data_w[1]), .O_rd_valid(rd_valid_w[1]), .O_ready(ready_w[1]));
  core_bus_target #(.WAIT_STATES(4'd2)) u_ws2 (
    .I_clock(clk), .I_reset(rst_n[2]), .I_phy2(phy2[2]), .I_addr(addr), .I_wr_data(wd),
    .I_rdwr(rdwr), .O_rd_data(rd_data_w[2]), .O_rd_valid(rd_valid_w[2]), .O_ready(ready_w[2]));

  // One 12-clock bus cycle on one target; samples every clock on the falling edge.
  task automatic run_cycle(input int inst, output logic ready_fall, output int vcnt,
                           output logic [7:0] data, output logic stable, output int dips);
    logic r0;
    vcnt = 0; data = 8'h00; stable = 1'b1; dips = 0; ready_fall = 1'b0; r0 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      phy2[inst] = (k < 6);
      @(posedge clk);
      @(negedge clk);
      if (rd_valid_w[inst]) begin
        if (vcnt == 0) data = rd_data_w[inst];
        vcnt++;
      end
      if (!ready_w[inst]) dips++;
      if (k == 0) r0 = ready_w[inst];
      else if ((k < 6) && (ready_w[inst] !== r0)) stable = 1'b0;
      if (k == 5) ready_fall = ready_w[inst];
    end
  endtask

  // Core-side access: repeats the bus cycle while O_ready is low; scoreboards read data.
  task automatic bus_access(input int inst, input logic [15:0] a, input logic rw,
                            input logic [7:0] d, output int stalls, output int vcnt,
                            output int dips, output logic stable);
    logic sel, rf, st, seen, timeout;
    int vc, dp;
    logic [7:0] dat, got, exp;
    addr = a; rdwr = rw; wd = d;
    sel = ((a & 16'hE000) == 16'h0000);
    if (sel && (rw == RW_READ)) exp_q.push_back(model_mem[inst][a[10:0]]);
    stalls = 0; vcnt = 0; dips = 0; stable = 1'b1; seen = 1'b0; got = 8'h00; timeout = 1'b1;
    for (int c = 0; c < 20; c++) begin
      run_cycle(inst, rf, vc, dat, st, dp);
      if ((vc > 0) && !seen) begin seen = 1'b1; got = dat; end
      vcnt += vc; dips += dp;
      if (!st) stable = 1'b0;
      if (rf) begin timeout = 1'b0; break; end
      stalls++;
    end
    checks++;
    if (timeout) begin
      errors++;
      $display("FAIL timeout inst%0d addr %h: ready still low after 20 bus cycles, required high", inst, a);
    end
    if (sel && (rw == RW_READ)) begin
      exp = exp_q.pop_front();
      checks++;
      if (!seen || (got !== exp)) begin
        errors++;
        $display("FAIL rd_data inst%0d addr %h: got %h (valid seen %0d) expected %h", inst, a, got, seen, exp);
      end
    end else if (sel && !timeout) begin
      model_mem[inst][a[10:0]] = d;
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ready_w[i] !== 1'b1) begin errors++; $display("FAIL reset_ready inst%0d: got %b expected 1", i, ready_w[i]); end
      checks++;
      if (rd_valid_w[i] !== 1'b0) begin errors++; $display("FAIL reset_valid inst%0d: got %b expected 0", i, rd_valid_w[i]); end
      checks++;
      if (rd_data_w[i] !== 8'h00) begin errors++; $display("FAIL reset_data inst%0d: got %h expected 00", i, rd_data_w[i]); end
    end
  endtask

  task automatic test_basic;
    int st, vc, dp; logic sb;
    bus_access(0, 16'h0123, RW_WRITE, 8'hA5, st, vc, dp, sb);
    checks++;
    if (vc !== 0) begin errors++; $display("FAIL basic_wr_valid: got %0d valid clocks expected 0", vc); end
    bus_access(0, 16'h0123, RW_READ, 8'h00, st, vc, dp, sb);
    checks++;
    if (vc !== 6) begin errors++; $display("FAIL basic_rd_valid_len: got %0d valid clocks expected 6", vc); end
    checks++;
    if ((dp !== 0) || (st !== 0)) begin errors++; $display("FAIL basic_ready: got %0d low samples %0d stalls expected 0 0", dp, st); end
  endtask

  task automatic test_mirror;
    int st, vc, dp; logic sb;
    bus_access(0, 16'h0800, RW_WRITE, 8'h3C, st, vc, dp, sb);
    bus_access(0, 16'h1800, RW_READ, 8'h00, st, vc, dp, sb);
    bus_access(0, 16'h0000, RW_READ, 8'h00, st, vc, dp, sb);
    checks++;
    if (vc !== 6) begin errors++; $display("FAIL mirror_valid_len: got %0d expected 6", vc); end
  endtask

  task automatic test_outside;
    int st, vc, dp; logic sb;
    bus_access(0, 16'h4000, RW_READ, 8'h00, st, vc, dp, sb);
    checks++;
    if ((vc !== 0) || (dp !== 0)) begin errors++; $display("FAIL outside_rd: got valid %0d ready-low %0d expected 0 0", vc, dp); end
    bus_access(0, 16'h4000, RW_WRITE, 8'hFF, st, vc, dp, sb);
    bus_access(1, 16'h4000, RW_READ, 8'h00, st, vc, dp, sb);
    checks++;
    if ((st !== 0) || (vc !== 0)) begin errors++; $display("FAIL outside_ws3: got stalls %0d valid %0d expected 0 0", st, vc); end
    bus_access(0, 16'h0000, RW_READ, 8'h00, st, vc, dp, sb);
  endtask

  task automatic test_wait_states;
    int st, vc, dp; logic sb;
    bus_access(1, 16'h0010, RW_WRITE, 8'h96, st, vc, dp, sb);
    checks++;
    if (st !== 3) begin errors++; $display("FAIL ws3_wr_stalls: got %0d expected 3", st); end
    bus_access(1, 16'h0010, RW_READ, 8'h00, st, vc, dp, sb);
    checks++;
    if (st !== 3) begin errors++; $display("FAIL ws3_rd_stalls: got %0d expected 3", st); end
    checks++;
    if (vc !== 6) begin errors++; $display("FAIL ws3_rd_valid_len: got %0d expected 6", vc); end
    checks++;
    if (sb !== 1'b1) begin errors++; $display("FAIL ws3_ready_stable: got %b expected 1", sb); end
  endtask

  task automatic test_reset_abort;
    int st, vc, dp; logic sb, rf; logic [7:0] dat;
    bus_access(2, 16'h0020, RW_WRITE, 8'h11, st, vc, dp, sb);
    checks++;
    if (st !== 2) begin errors++; $display("FAIL ws2_stalls: got %0d expected 2", st); end
    addr = 16'h0020; rdwr = RW_WRITE; wd = 8'h77;
    run_cycle(2, rf, vc, dat, sb, dp);
    phy2[2] = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (ready_w[2] !== 1'b0) begin errors++; $display("FAIL abort_stalled: got ready %b expected 0", ready_w[2]); end
    rst_n[2] = 1'b0;
    #1;
    checks++;
    if (ready_w[2] !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", ready_w[2]); end
    phy2[2] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n[2] = 1'b1;
    repeat (2) @(negedge clk);
    bus_access(2, 16'h0020, RW_READ, 8'h00, st, vc, dp, sb);
  endtask

  task automatic test_back_to_back;
    int st, vc, dp, total_st, total_dp; logic sb;
    bus_access(0, 16'h0001, RW_WRITE, 8'h5E, st, vc, dp, sb);
    total_st = 0; total_dp = 0;
    bus_access(0, 16'h0001, RW_READ, 8'h00, st, vc, dp, sb);
    total_st += st; total_dp += dp;
    bus_access(0, 16'h0002, RW_WRITE, 8'hC3, st, vc, dp, sb);
    total_st += st; total_dp += dp;
    bus_access(0, 16'h0002, RW_READ, 8'h00, st, vc, dp, sb);
    total_st += st; total_dp += dp;
    checks++;
    if ((total_st !== 0) || (total_dp !== 0)) begin errors++; $display("FAIL b2b_no_stall: got stalls %0d ready-low %0d expected 0 0", total_st, total_dp); end
  endtask

  initial begin
    rst_n = 3'b000; phy2 = 3'b000; addr = 16'h0000; wd = 8'h00; rdwr = RW_READ;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 3'b111;
    repeat (2) @(negedge clk);
    test_basic;
    test_mirror;
    test_outside;
    test_wait_states;
    test_reset_abort;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
